// File: rtl/gen_clk_pkg.sv
// gen_clk_pkg: shared types and constants for the gen_clk_divider block.
//   state_t : ratio-tracking FSM states (ACQUIRE, LOCKED, SWITCH)
//   DIV_MIN : smallest legal divide ratio
package gen_clk_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,   // counting stable periods towards lock
        LOCKED  = 2'd1,   // ratio stable, lock asserted
        SWITCH  = 2'd2    // new ratio pending, applied at the next wrap
    } state_t;

    localparam int DIV_MIN = 2;

endpackage

// File: rtl/gen_clk_divider_div_counter.sv
// div_counter: period counter producing the registered divided clock.
//   clk    : source clock
//   rst    : asynchronous active-high reset
//   div    : active divide ratio (>= 2)
//   wrap   : high in the cycle the counter sits at div-1 (end of a period)
//   clkout : divided clock, high floor(div/2) cycles, low ceil(div/2) cycles
//   clk_en : one-cycle pulse in the cycle clkout rises
module div_counter #(
    parameter int CNT_W   = 8,
    parameter int RST_CNT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] div,
    output logic             wrap,
    output logic             clkout,
    output logic             clk_en
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;

    assign wrap     = (cnt == div - CNT_W'(1));
    assign next_cnt = wrap ? '0 : cnt + CNT_W'(1);

    // Resetting cnt to div-1 makes the very first edge after reset a wrap,
    // so the output starts with a rising edge and an enable pulse.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= CNT_W'(RST_CNT);
            clkout <= 1'b0;
            clk_en <= 1'b0;
        end else begin
            cnt    <= next_cnt;
            clkout <= (next_cnt < (div >> 1));
            clk_en <= (next_cnt == '0);
        end
    end

endmodule

// File: rtl/gen_clk_divider.sv
// gen_clk_divider: programmable counter-based clock divider with a runtime
// ratio-change handshake and a lock indicator.
//   clk       : source clock
//   rst       : asynchronous active-high reset
//   cfg_div   : requested divide ratio
//   cfg_valid : request strobe for cfg_div
//   cfg_ready : a request can be accepted this cycle (low while a switch is pending)
//   cfg_err   : one-cycle pulse after an accepted request with cfg_div < 2
//   clkout    : registered divided clock
//   clk_en    : one-cycle pulse in the cycle clkout rises
//   locked    : ratio stable for at least LOCK_PERIODS complete periods
module gen_clk_divider
    import gen_clk_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_DIV  = 2,
    parameter int LOCK_PERIODS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clkout,
    output logic             clk_en,
    output logic             locked
);

    localparam int LC_W = $clog2(LOCK_PERIODS + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] div, div_nxt;
    logic [CNT_W-1:0] pend_div, pend_nxt;
    logic [LC_W-1:0]  lock_cnt, lock_nxt;
    logic             cfg_err_nxt;
    logic             started;
    logic             wrap;
    logic             accept;

    div_counter #(
        .CNT_W   (CNT_W),
        .RST_CNT (DEFAULT_DIV - 1)
    ) u_div_counter (
        .clk    (clk),
        .rst    (rst),
        .div    (div),
        .wrap   (wrap),
        .clkout (clkout),
        .clk_en (clk_en)
    );

    assign cfg_ready = (state != SWITCH);
    assign accept    = cfg_valid & cfg_ready;
    assign locked    = (state == LOCKED);

    // NOTE: every variable written here is given a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        div_nxt     = div;
        pend_nxt    = pend_div;
        lock_nxt    = lock_cnt;
        cfg_err_nxt = 1'b0;

        case (state)
            ACQUIRE: begin
                // The wrap at the first edge after reset closes no real
                // period, so only wraps after that one are counted.
                if (wrap && started) begin
                    lock_nxt = lock_cnt + LC_W'(1);
                    if (lock_cnt == LC_W'(LOCK_PERIODS - 1)) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
            end
            SWITCH: begin
                // Counter restarts at 0 on this same edge, so the new
                // ratio governs a full fresh period.
                if (wrap) begin
                    div_nxt   = pend_div;
                    lock_nxt  = '0;
                    state_nxt = ACQUIRE;
                end
            end
            default: state_nxt = ACQUIRE;
        endcase

        // A request accepted on a wrap overrides the ACQUIRE/LOCKED
        // outcome above; the switch itself waits for the following wrap.
        if (accept) begin
            if (cfg_div < CNT_W'(DIV_MIN)) begin
                cfg_err_nxt = 1'b1;
            end else if (cfg_div != div) begin
                pend_nxt  = cfg_div;
                state_nxt = SWITCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACQUIRE;
            div      <= CNT_W'(DEFAULT_DIV);
            pend_div <= '0;
            lock_cnt <= '0;
            cfg_err  <= 1'b0;
            started  <= 1'b0;
        end else begin
            state    <= state_nxt;
            div      <= div_nxt;
            pend_div <= pend_nxt;
            lock_cnt <= lock_nxt;
            cfg_err  <= cfg_err_nxt;
            started  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gen_clk_divider.sv
// tb_gen_clk_divider: self-checking bench for gen_clk_divider.
// A period-level reference model predicts every output each cycle; directed
// sequences add hand-computed literal expectations.
module tb_gen_clk_divider;

    localparam int CNT_W        = 8;
    localparam int DEFAULT_DIV  = 2;
    localparam int LOCK_PERIODS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clkout;
    logic             clk_en;
    logic             locked;

    int n_checks = 0;
    int n_err    = 0;

    gen_clk_divider #(
        .CNT_W        (CNT_W),
        .DEFAULT_DIV  (DEFAULT_DIV),
        .LOCK_PERIODS (LOCK_PERIODS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clkout    (clkout),
        .clk_en    (clk_en),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_pos: position of the current cycle inside its output period
    //        (-1 = no period started since reset)
    // m_pend: pending ratio (0 = none); m_good: complete periods at this ratio
    int m_div  = DEFAULT_DIV;
    int m_pos  = -1;
    int m_pend = 0;
    int m_good = 0;
    bit m_err  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div  = DEFAULT_DIV;
            m_pos  = -1;
            m_pend = 0;
            m_good = 0;
            m_err  = 1'b0;
        end else begin
            bit acc;
            int d;
            acc   = cfg_valid && (m_pend == 0);
            d     = int'(cfg_div);
            m_err = 1'b0;
            if (m_pos == -1 || m_pos == m_div - 1) begin
                if (m_pend != 0) begin
                    m_div  = m_pend;
                    m_pend = 0;
                    m_good = 0;
                end else if (m_pos != -1) begin
                    m_good++;
                end
                m_pos = 0;
            end else begin
                m_pos++;
            end
            if (acc) begin
                if (d < 2) m_err = 1'b1;
                else if (d != m_div) m_pend = d;
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        check("cmp clkout",    32'(clkout),    32'(m_pos >= 0 && m_pos < m_div / 2));
        check("cmp clk_en",    32'(clk_en),    32'(m_pos == 0));
        check("cmp locked",    32'(locked),    32'(m_pend == 0 && m_good >= LOCK_PERIODS));
        check("cmp cfg_ready", 32'(cfg_ready), 32'(m_pend == 0));
        check("cmp cfg_err",   32'(cfg_err),   32'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; holds the request across one rising edge and
    // returns at the following negedge with cfg_valid dropped.
    task automatic request(input logic [CNT_W-1:0] d);
        cfg_valid = 1'b1;
        cfg_div   = d;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cfg_ready === 1'b1) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_locked(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (locked === 1'b1) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_clk_en(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (clk_en === 1'b1) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Samples n consecutive clkout values, first one at the current negedge.
    task automatic grab(input int n, output logic [15:0] pat);
        pat = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            pat = {pat[14:0], clkout};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] pat;

        // reset state
        repeat (3) @(negedge clk);
        check("rst clkout",    32'(clkout),    32'd0);
        check("rst clk_en",    32'(clk_en),    32'd0);
        check("rst locked",    32'(locked),    32'd0);
        check("rst cfg_err",   32'(cfg_err),   32'd0);
        check("rst cfg_ready", 32'(cfg_ready), 32'd1);
        #1 rst = 1'b0;

        // default ratio 2: clk_en on odd cycles, locked from cycle 9
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("boot clkout c%0d", k), 32'(clkout), 32'(k % 2));
            check($sformatf("boot clk_en c%0d", k), 32'(clk_en), 32'(k % 2));
            check($sformatf("boot locked c%0d", k), 32'(locked), 32'(k >= 9));
        end

        // change to 5 while locked
        request(8'd5);
        check("sw5 ready low", 32'(cfg_ready), 32'd0);
        check("sw5 locked low", 32'(locked), 32'd0);
        wait_ready("sw5 ready return", 20);
        check("sw5 clk_en at switch", 32'(clk_en), 32'd1);
        grab(5, pat);
        check("sw5 period shape", 32'(pat[4:0]), 32'b11000);
        @(negedge clk);
        check("sw5 next clk_en", 32'(clk_en), 32'd1);
        repeat (14) @(negedge clk);
        check("sw5 locked before 5th", 32'(locked), 32'd0);
        @(negedge clk);
        check("sw5 locked at 5th", 32'(locked), 32'd1);

        // illegal ratios
        request(8'd1);
        check("err1 pulse", 32'(cfg_err), 32'd1);
        @(negedge clk);
        check("err1 clear", 32'(cfg_err), 32'd0);
        request(8'd0);
        check("err0 pulse", 32'(cfg_err), 32'd1);
        check("err0 locked kept", 32'(locked), 32'd1);
        @(negedge clk);
        check("err0 clear", 32'(cfg_err), 32'd0);
        check("err0 ready", 32'(cfg_ready), 32'd1);

        // back to 2, then a same-ratio no-op
        request(8'd2);
        wait_locked("relock 2", 60);
        request(8'd2);
        check("noop cfg_err", 32'(cfg_err), 32'd0);
        check("noop locked", 32'(locked), 32'd1);
        check("noop ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        check("noop locked later", 32'(locked), 32'd1);

        // ratio 3, then accept 7 on a wrap edge
        request(8'd3);
        wait_locked("relock 3", 60);
        wait_clk_en("align 3", 10);
        repeat (2) @(negedge clk);          // cycle with cnt == div-1
        request(8'd7);
        check("sw7 clk_en at accept", 32'(clk_en), 32'd1);
        check("sw7 ready low", 32'(cfg_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("sw7 still old ratio", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        check("sw7 ready back", 32'(cfg_ready), 32'd1);
        check("sw7 clk_en switch", 32'(clk_en), 32'd1);
        grab(7, pat);
        check("sw7 period shape", 32'(pat[6:0]), 32'b1110000);
        @(negedge clk);
        check("sw7 next clk_en", 32'(clk_en), 32'd1);

        // reset in the middle of a switch to 9
        request(8'd9);
        check("sw9 ready low", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid rst clkout",    32'(clkout),    32'd0);
        check("mid rst clk_en",    32'(clk_en),    32'd0);
        check("mid rst locked",    32'(locked),    32'd0);
        check("mid rst cfg_err",   32'(cfg_err),   32'd0);
        check("mid rst cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post rst c1 clk_en", 32'(clk_en), 32'd1);
        check("post rst c1 clkout", 32'(clkout), 32'd1);
        @(negedge clk);
        check("post rst c2 clk_en", 32'(clk_en), 32'd0);
        check("post rst c2 clkout", 32'(clkout), 32'd0);
        @(negedge clk);
        check("post rst c3 clk_en", 32'(clk_en), 32'd1);
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
